// File: rtl/alpha_pkg.sv
// Shared types and widths for the alpha_processor memory-side blocks.
package alpha_pkg;

  localparam int ALPHA_AW = 32;
  localparam int ALPHA_DW = 32;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT_IF = 2'd1,
    WAIT_DM = 2'd2
  } arb_state_t;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_DM = 1'b1
  } owner_t;

endpackage

// File: rtl/alpha_rr_pick2.sv
// Two-way round-robin pick, purely combinational (zero latency); no backpressure.
// Bit 0 is the IF/first requester and bit 1 is the DM/second requester; 'last' holds the previous owner.
module alpha_rr_pick2
  import alpha_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = req;
    // On a tie, the side that did not own the port last time wins.
    if (req == 2'b11) begin
      gnt = (last == OWN_IF) ? 2'b10 : 2'b01;
    end
  end

endmodule

// File: rtl/alpha_mem_arbiter.sv
// Round-robin share of one memory port between fetch and load/store; grant and response are combinational pass-through.
// One transaction is outstanding at a time, and new requests stall until the response or the timeout abort.
module alpha_mem_arbiter
  import alpha_pkg::*;
#(
  parameter int AW      = ALPHA_AW,
  parameter int DW      = ALPHA_DW,
  parameter int TIMEOUT = 255
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            if_req,
  input  logic [AW-1:0]   if_addr,
  output logic            if_gnt,
  output logic            if_rvalid,
  output logic [DW-1:0]   if_rdata,
  input  logic            dm_req,
  input  logic            dm_we,
  input  logic [DW/8-1:0] dm_be,
  input  logic [AW-1:0]   dm_addr,
  input  logic [DW-1:0]   dm_wdata,
  output logic            dm_gnt,
  output logic            dm_rvalid,
  output logic [DW-1:0]   dm_rdata,
  output logic            mem_req,
  output logic            mem_we,
  output logic [DW/8-1:0] mem_be,
  output logic [AW-1:0]   mem_addr,
  output logic [DW-1:0]   mem_wdata,
  input  logic            mem_gnt,
  input  logic            mem_rvalid,
  input  logic [DW-1:0]   mem_rdata,
  output logic            err,
  output logic            busy
);

  // The counter only has to reach TIMEOUT-1.
  localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  arb_state_t     state_q, state_d;
  owner_t         last_q, last_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [1:0]     pick;
  logic           timed_out;

  alpha_rr_pick2 u_pick (
    .req  ({dm_req, if_req}),
    .last (last_q),
    .gnt  (pick)
  );

  assign timed_out = (cnt_q == CNT_LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      last_q  <= OWN_IF;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if ((|pick) && mem_gnt) begin
          state_d = pick[1] ? WAIT_DM : WAIT_IF;
          last_d  = pick[1] ? OWN_DM : OWN_IF;
          cnt_d   = '0;
        end
      end
      WAIT_IF, WAIT_DM: begin
        cnt_d = cnt_q + CW'(1);
        if (mem_rvalid || timed_out) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs are gated by reset so an asserted reset silences the port immediately.
  always_comb begin
    if_gnt    = 1'b0;
    if_rvalid = 1'b0;
    if_rdata  = '0;
    dm_gnt    = 1'b0;
    dm_rvalid = 1'b0;
    dm_rdata  = '0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_be    = '0;
    mem_addr  = '0;
    mem_wdata = '0;
    err       = 1'b0;
    busy      = 1'b0;
    if (reset) begin
      busy = (state_q != IDLE);
      case (state_q)
        IDLE: begin
          mem_req = |pick;
          if (pick[0]) begin
            mem_be   = '1;
            mem_addr = if_addr;
            if_gnt   = mem_gnt;
          end else if (pick[1]) begin
            mem_we    = dm_we;
            mem_be    = dm_be;
            mem_addr  = dm_addr;
            mem_wdata = dm_wdata;
            dm_gnt    = mem_gnt;
          end
        end
        WAIT_IF: begin
          if_rvalid = mem_rvalid || timed_out;
          if_rdata  = mem_rvalid ? mem_rdata : '0;
          err       = !mem_rvalid && timed_out;
        end
        WAIT_DM: begin
          dm_rvalid = mem_rvalid || timed_out;
          dm_rdata  = mem_rvalid ? mem_rdata : '0;
          err       = !mem_rvalid && timed_out;
        end
        default: ;
      endcase
    end
  end

endmodule
